// File: rtl/rf_operand_fetch.sv
// rtl/rf_operand_fetch.sv - operand fetch with pending-write scoreboard, forwarding and one-entry output register
module rf_operand_fetch #(
  parameter int DATA_WIDTH = 16,
  parameter int SEL_BITS   = 3,
  parameter int NUM_REGS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [SEL_BITS-1:0]   src1_sel,
  input  logic [SEL_BITS-1:0]   src2_sel,
  input  logic                  src1_used,
  input  logic                  src2_used,
  input  logic [SEL_BITS-1:0]   dst_sel,
  input  logic                  dst_en,
  output logic [SEL_BITS-1:0]   rf_read1_sel,
  output logic [SEL_BITS-1:0]   rf_read2_sel,
  input  logic [DATA_WIDTH-1:0] rf_read1_data,
  input  logic [DATA_WIDTH-1:0] rf_read2_data,
  input  logic                  wb_valid,
  input  logic [SEL_BITS-1:0]   wb_sel,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic [SEL_BITS-1:0]   op_dst,
  output logic                  op_dst_en,
  output logic                  err
);

  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   pending_next;
  logic                  fwd1, fwd2, wb_hits_dst;
  logic                  raw1, raw2, waw;
  logic                  slot_free, accept;
  logic [DATA_WIDTH-1:0] opnd1, opnd2;

  assign rf_read1_sel = src1_sel;
  assign rf_read2_sel = src2_sel;

  // A writeback landing this cycle is not yet visible in the register file read data.
  assign fwd1        = wb_valid && (wb_sel == src1_sel);
  assign fwd2        = wb_valid && (wb_sel == src2_sel);
  assign wb_hits_dst = wb_valid && (wb_sel == dst_sel);
  assign opnd1       = fwd1 ? wb_data : rf_read1_data;
  assign opnd2       = fwd2 ? wb_data : rf_read2_data;

  // A pending register completing this cycle no longer blocks its readers or writers.
  assign raw1 = src1_used && pending[src1_sel] && !fwd1;
  assign raw2 = src2_used && pending[src2_sel] && !fwd2;
  assign waw  = dst_en && pending[dst_sel] && !wb_hits_dst;

  assign slot_free   = !op_valid || op_ready;
  assign issue_ready = slot_free && !raw1 && !raw2 && !waw;
  assign accept      = issue_valid && issue_ready;

  // Scoreboard next state: clear on writeback first so a same-cycle set wins.
  always_comb begin
    pending_next = pending;
    if (wb_valid)
      pending_next[wb_sel] = 1'b0;
    if (accept && dst_en)
      pending_next[dst_sel] = 1'b1;
  end

  // Scoreboard state and sticky error for writebacks nobody was waiting on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      err     <= 1'b0;
    end else begin
      pending <= pending_next;
      if (wb_valid && !pending[wb_sel])
        err <= 1'b1;
    end
  end

  // Output bundle register: load on accept, drain on downstream take, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_valid  <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_dst    <= '0;
      op_dst_en <= 1'b0;
    end else if (accept) begin
      op_valid  <= 1'b1;
      op_a      <= opnd1;
      op_b      <= opnd2;
      op_dst    <= dst_sel;
      op_dst_en <= dst_en;
    end else if (op_ready) begin
      op_valid  <= 1'b0;
    end
  end

endmodule
